// File: rtl/vexriscv_ram_loader.sv
// vexriscv_ram_loader: loads a checksummed byte-stream image into RAM, reads it back to verify, then releases the CPU
// clk, rst       : single clock, synchronous active-high reset
// rx_data/valid  : incoming bytes; rx_ready high when a byte can be taken
// mem_*          : RAM port (word address, byte write enables, data in/out)
// cpu_rst        : high in every state except DONE
// load_done/err  : image verified / frame or checksum error
module vexriscv_ram_loader #(
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);
    typedef enum logic [3:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, VERIFY, DONE, ERR} state_t;
    state_t state, state_n;
    logic [15:0] cnt, widx;
    logic [16:0] vc;
    logic [1:0]  bidx;
    logic [23:0] word;
    logic [7:0]  rx_sum, rb_sum, csum, rb_next;
    logic        fire, sample, last;
    assign fire = rx_valid && rx_ready;
    // vc counts VERIFY cycles; read data for the read issued in cycle vc arrives while vc+1 is current
    always_comb begin
        sample  = state == VERIFY && vc != 17'd0;
        rb_next = rb_sum + (sample ? 8'(mem_dout[7:0] + mem_dout[15:8] + mem_dout[23:16] + mem_dout[31:24]) : 8'd0);
        last    = vc == {1'b0, cnt};
        state_n = state;
        case (state)
            IDLE:    state_n = (fire && rx_data == 8'hA5) ? LEN0 : IDLE;
            LEN0:    state_n = fire ? LEN1 : LEN0;
            LEN1:    state_n = !fire ? LEN1 :
                               ({rx_data, cnt[7:0]} == 16'd0) ? CSUM :
                               ({1'b0, rx_data, cnt[7:0]} > 17'(RAM_DEPTH)) ? ERR : DATA;
            DATA:    state_n = (fire && bidx == 2'd3) ? WRITE : DATA;
            WRITE:   state_n = (widx + 16'd1 == cnt) ? CSUM : DATA;
            CSUM:    state_n = fire ? VERIFY : CSUM;
            VERIFY:  state_n = !last ? VERIFY : (rb_next == csum && rx_sum == csum) ? DONE : ERR;
            DONE:    state_n = DONE;
            ERR:     state_n = (fire && rx_data == 8'hA5) ? LEN0 : ERR;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            mem_addr  <= '0;
            mem_din   <= 32'h0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt       <= 16'h0;
            widx      <= 16'h0;
            vc        <= 17'h0;
            bidx      <= 2'd0;
            word      <= 24'h0;
            rx_sum    <= 8'h0;
            rb_sum    <= 8'h0;
            csum      <= 8'h0;
        end else begin
            state     <= state_n;
            rx_ready  <= state_n inside {IDLE, LEN0, LEN1, DATA, CSUM, ERR};
            cpu_rst   <= state_n != DONE;
            load_done <= state_n == DONE;
            load_err  <= state_n == ERR;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            case (state)
                IDLE, ERR: if (fire && rx_data == 8'hA5) begin
                    cnt    <= 16'h0;
                    widx   <= 16'h0;
                    vc     <= 17'h0;
                    bidx   <= 2'd0;
                    word   <= 24'h0;
                    rx_sum <= 8'h0;
                    rb_sum <= 8'h0;
                    csum   <= 8'h0;
                end
                LEN0: if (fire) cnt[7:0] <= rx_data;
                LEN1: if (fire) cnt[15:8] <= rx_data;
                DATA: if (fire) begin
                    rx_sum <= rx_sum + rx_data;
                    bidx   <= bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 4'hF;
                        mem_addr <= widx[ADDR_W-1:0];
                        mem_din  <= {rx_data, word};
                    end else begin
                        word[{bidx, 3'b000} +: 8] <= rx_data;
                    end
                end
                WRITE: widx <= widx + 16'd1;
                // first read goes out in the first VERIFY cycle
                CSUM: if (fire) begin
                    csum     <= rx_data;
                    vc       <= 17'h0;
                    mem_en   <= cnt != 16'h0;
                    mem_addr <= '0;
                end
                VERIFY: begin
                    vc     <= vc + 17'd1;
                    rb_sum <= rb_next;
                    if (vc + 17'd1 < {1'b0, cnt}) begin
                        mem_en   <= 1'b1;
                        mem_addr <= ADDR_W'(vc + 17'd1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vexriscv_ram_loader.sv
// tb_vexriscv_ram_loader: scoreboard bench for the RAM loader with a RAM model and directed frames
module tb_vexriscv_ram_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    vexriscv_ram_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit w; int addr; logic [31:0] data; } op_t;
    typedef struct { bit d; bit e; int lat; } res_t;
    op_t  op_q[$];
    res_t res_q[$];
    op_t  mo;
    res_t mr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit corrupt = 1'b0;
    bit term_prev = 1'b0;
    logic [31:0] ram [1024];
    logic [31:0] dout_r = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial for (int i = 0; i < 1024; i++) ram[i] = 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we == 4'hF) ram[mem_addr] <= mem_din;
            dout_r <= ram[mem_addr];
        end
    end
    assign mem_dout = dout_r ^ {31'h0, corrupt};

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (op_q.size() == 0) chk("unexpected_mem_en", {mem_we, 18'h0, mem_addr}, 32'h0);
                else begin
                    mo = op_q.pop_front();
                    chk("mem_we", {28'h0, mem_we}, mo.w ? 32'hF : 32'h0);
                    chk("mem_addr", {22'h0, mem_addr}, mo.addr);
                    if (mo.w) chk("mem_din", mem_din, mo.data);
                end
            end
            if ((load_done || load_err) && !term_prev) begin
                if (res_q.size() == 0) chk("unexpected_result", {30'h0, load_done, load_err}, 32'h0);
                else begin
                    mr = res_q.pop_front();
                    chk("load_done", {31'h0, load_done}, {31'h0, mr.d});
                    chk("load_err", {31'h0, load_err}, {31'h0, mr.e});
                    chk("cpu_rst", {31'h0, cpu_rst}, {31'h0, !mr.d});
                    chk("latency", cyc - acc_cyc, mr.lat);
                end
            end
        end
        term_prev <= load_done || load_err;
    end

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        bit acc;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data = b;
        rx_valid = 1'b1;
        t = 0;
        forever begin
            acc = rx_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 200) begin chk("rx_ready_timeout", 32'h0, 32'h1); break; end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_std(input logic [7:0] cs, input int maxgap);
        logic [7:0] f [12] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
        f[11] = cs;
        for (int i = 0; i < 12; i++) send(f[i], maxgap == 0 ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic exp_std(input bit d);
        op_q.push_back('{1'b1, 0, 32'h04030201});
        op_q.push_back('{1'b1, 1, 32'h08070605});
        op_q.push_back('{1'b0, 0, 32'h0});
        op_q.push_back('{1'b0, 1, 32'h0});
        res_q.push_back('{d, !d, 4});
    endtask

    task automatic drain();
        int t = 0;
        while ((op_q.size() != 0 || res_q.size() != 0) && t < 500) begin @(posedge clk); #1; t++; end
        chk("drain", op_q.size() + res_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        corrupt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {rx_ready, mem_en, mem_we, cpu_rst, load_done, load_err}, 9'b0_0_0000_1_0_0);
        chk("rst_addr_din", {22'h0, mem_addr} | mem_din, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        exp_std(1'b1);
        send_std(8'h24, 0);
        drain();
        chk("done_held", {30'h0, load_done, cpu_rst}, 32'h2);

        do_reset();
        exp_std(1'b0);
        send_std(8'h25, 0);
        drain();
        chk("err_held", {29'h0, load_err, cpu_rst, rx_ready}, 32'h7);
        exp_std(1'b1);
        send_std(8'h24, 0);
        drain();
        chk("recovered", {30'h0, load_done, load_err}, 32'h2);

        do_reset();
        res_q.push_back('{1'b1, 1'b0, 2});
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        drain();

        do_reset();
        res_q.push_back('{1'b0, 1'b1, 1});
        send(8'hA5, 0); send(8'h01, 0); send(8'h04, 0);
        drain();

        do_reset();
        send(8'h00, 1); send(8'hFF, 2);
        exp_std(1'b1);
        send_std(8'h24, 3);
        drain();

        do_reset();
        corrupt = 1'b1;
        exp_std(1'b0);
        send_std(8'h24, 0);
        drain();
        corrupt = 1'b0;

        do_reset();
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        op_q.push_back('{1'b1, 0, 32'h04030201});
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
        for (int i = 1; i <= 5; i++) send(8'(i), 0);
        @(posedge clk); #1;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_word0", ram[0], 32'h04030201);
        chk("abort_word1", ram[1], 32'h0);
        chk("abort_outputs", {29'h0, cpu_rst, load_done, load_err}, 32'h4);
        exp_std(1'b1);
        send_std(8'h24, 0);
        drain();
        chk("final_ram1", ram[1], 32'h08070605);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
